// File: rtl/store_narrow_unit_pkg.sv
// Shared encodings for the store narrowing unit: access sizes, FSM states,
// strobe base patterns and the alignment rule used when accepting a store.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // Reserved size is reported as misaligned so it never reaches memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Store request and data-memory write channel of the store narrowing unit.
// master = pipeline/memory side, slave = the unit itself.
interface store_narrow_unit_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wready,
        input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wready,
        output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_narrow_unit_align.sv
// Combinational lane placement, strobe generation and misalign detection.
// With STORE_TRUNC_CHECK_EN defined it also flags lossy byte/half narrowing.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misalign
`ifdef STORE_TRUNC_CHECK_EN
    ,
    output logic        trunc
`endif
);

    // Every lane carries the datum that would land there for its size, so the
    // strobes alone select the bytes memory actually writes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[gi*8 +: 8] = (size == SZ_BYTE) ? data[7:0] :
                                      (size == SZ_HALF) ? data[(gi % 2)*8 +: 8] :
                                                          data[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        wstrb = 4'b0000;
        case (size)
            SZ_BYTE: wstrb = STRB_BYTE << lane;
            SZ_HALF: wstrb = STRB_HALF << lane;
            SZ_WORD: wstrb = STRB_WORD;
            default: wstrb = 4'b0000;
        endcase
    end

    assign misalign = is_misaligned(size, lane);

`ifdef STORE_TRUNC_CHECK_EN
    logic [31:0] byte_sext, byte_zext, half_sext, half_zext;

    assign byte_sext = {{24{data[7]}}, data[7:0]};
    assign byte_zext = {24'h000000, data[7:0]};
    assign half_sext = {{16{data[15]}}, data[15:0]};
    assign half_zext = {16'h0000, data[15:0]};

    // Lossy only when the register value is neither the signed nor the
    // unsigned reading of the narrowed datum.
    always_comb begin
        trunc = 1'b0;
        case (size)
            SZ_BYTE: trunc = (data != byte_sext) && (data != byte_zext);
            SZ_HALF: trunc = (data != half_sext) && (data != half_zext);
            default: trunc = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: places SB/SH/SW data on byte lanes and runs the memory
// write handshake with timeout. Optional lossy-narrow flag: STORE_TRUNC_CHECK_EN.
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    store_narrow_unit_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_misalign,
    output logic                 err_timeout,
    output logic                 err_trunc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       waddr_reg, waddr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;
    logic              done_reg, done_next;
    logic              misalign_reg, misalign_next;
    logic              timeout_reg, timeout_next;

    logic [31:0]       al_wdata;
    logic [3:0]        al_wstrb;
    logic              al_misalign;
    logic              accept;

`ifdef STORE_TRUNC_CHECK_EN
    logic              al_trunc;
    logic              trunc_pend_reg, trunc_pend_next;
    logic              trunc_reg, trunc_next;
`endif

    store_lane_align u_align (
        .lane     (bus.st_addr[1:0]),
        .size     (bus.st_size),
        .data     (bus.st_data),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb),
        .misalign (al_misalign)
`ifdef STORE_TRUNC_CHECK_EN
        ,
        .trunc    (al_trunc)
`endif
    );

    assign bus.st_ready   = (state_reg == S_IDLE);
    assign busy           = ~bus.st_ready;
    assign accept         = bus.st_valid && bus.st_ready;
    assign bus.mem_wvalid = (state_reg == S_ISSUE);
    assign bus.mem_waddr  = waddr_reg;
    assign bus.mem_wdata  = wdata_reg;
    assign bus.mem_wstrb  = wstrb_reg;
    assign done           = done_reg;
    assign err_misalign   = misalign_reg;
    assign err_timeout    = timeout_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        done_next     = 1'b0;
        misalign_next = 1'b0;
        timeout_next  = 1'b0;
`ifdef STORE_TRUNC_CHECK_EN
        trunc_pend_next = trunc_pend_reg;
        trunc_next      = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (al_misalign) begin
                        misalign_next = 1'b1;
                    end else begin
                        waddr_next = {bus.st_addr[31:2], 2'b00};
                        wdata_next = al_wdata;
                        wstrb_next = al_wstrb;
                        cnt_next   = '0;
                        state_next = S_ISSUE;
`ifdef STORE_TRUNC_CHECK_EN
                        trunc_pend_next = al_trunc;
`endif
                    end
                end
            end
            S_ISSUE: begin
                // Acceptance is tested first so a last-cycle wready still wins.
                if (bus.mem_wready) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
`ifdef STORE_TRUNC_CHECK_EN
                    trunc_next = trunc_pend_reg;
`endif
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            done_reg     <= done_next;
            misalign_reg <= misalign_next;
            timeout_reg  <= timeout_next;
        end
    end

`ifdef STORE_TRUNC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trunc_pend_reg <= 1'b0;
            trunc_reg      <= 1'b0;
        end else begin
            trunc_pend_reg <= trunc_pend_next;
            trunc_reg      <= trunc_next;
        end
    end

    assign err_trunc = trunc_reg;
`else
    assign err_trunc = 1'b0;
`endif

endmodule
